game_clock_ctrl: RTL and testbench

// Game-level master for the 24 s shot-clock counter: drives its enable/reload/hold inputs and consumes its

---
 rtl/game_clock_ctrl_if.sv | 27 ++
 rtl/game_clock_ctrl.sv | 131 +++++++++++++
 tb/tb_game_clock_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/game_clock_ctrl_if.sv
// Referee/shot-clock/scoreboard signal bundle for the game clock controller.
// The master drives referee and counter inputs; the slave is the controller.
interface game_clock_ctrl_if #(
   parameter int unsigned N = 8
) ();
   logic         start_sw;
   logic         poss_change;
   logic         shot_cout;
   logic         shot_en;
   logic         shot_rst;
   logic         shot_hold;
   logic [N-1:0] min_N;
   logic [N-1:0] sec_N;
   logic [N-1:0] quarter_N;
   logic         buzzer;
   logic         game_over;

   modport master (
      output start_sw, poss_change, shot_cout,
      input  shot_en, shot_rst, shot_hold, min_N, sec_N, quarter_N, buzzer, game_over
   );

   modport slave (
      input  start_sw, poss_change, shot_cout,
      output shot_en, shot_rst, shot_hold, min_N, sec_N, quarter_N, buzzer, game_over
   );
endinterface

// File: rtl/game_clock_ctrl.sv
// Game-level master for the 24 s shot clock: quarter countdown, quarter number,
// buzzer and run/pause control, advancing once per 1 Hz tick.
module game_clock_ctrl #(
   parameter int unsigned N           = 8,
   parameter int unsigned QUARTER_MIN = 12,
   parameter int unsigned QUARTERS    = 4,
   parameter int unsigned BUZZ_LEN    = 3,
   parameter int unsigned SHOT_LEN    = 24
) (
   input logic              clk_1Hz,
   input logic              Reset_Game,
   game_clock_ctrl_if.slave gc
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_PAUSE = 3'd2;
   localparam logic [2:0] S_VIOL  = 3'd3;
   localparam logic [2:0] S_QEND  = 3'd4;
   localparam logic [2:0] S_OVER  = 3'd5;

   localparam int unsigned BW = $clog2(BUZZ_LEN + 1);
   localparam int unsigned RW = N + 6;

   localparam logic [N-1:0]  QMIN     = N'(QUARTER_MIN);
   localparam logic [N-1:0]  SEC_MAX  = N'(59);
   localparam logic [N-1:0]  QTR_LAST = N'(QUARTERS);
   localparam logic [BW-1:0] BUZZ_END = BW'(BUZZ_LEN - 1);

   logic [2:0]    state;
   logic [N-1:0]  min_q;
   logic [N-1:0]  sec_q;
   logic [N-1:0]  qtr_q;
   logic [BW-1:0] buzz_cnt;
   logic          start_q;
   logic          rst_pend;

   logic [RW-1:0] rem;
   logic          hold;
   logic          start_rise;
   logic          last_sec;
   logic          buzz_done;

   assign rem        = RW'(min_q) * RW'(60) + RW'(sec_q);
   assign hold       = (rem <= RW'(SHOT_LEN));
   assign start_rise = gc.start_sw & ~start_q;
   assign last_sec   = (min_q == '0) && (sec_q == N'(1));
   assign buzz_done  = (buzz_cnt == BUZZ_END);

   always_ff @(posedge clk_1Hz) begin
      if (Reset_Game) begin
         state    <= S_IDLE;
         min_q    <= QMIN;
         sec_q    <= '0;
         qtr_q    <= N'(1);
         buzz_cnt <= '0;
         start_q  <= 1'b0;
         rst_pend <= 1'b0;
      end else begin
         start_q  <= gc.start_sw;
         rst_pend <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_rise) state <= S_RUN;
            end
            S_RUN: begin
               rst_pend <= gc.poss_change;
               // Period end is checked before the violation so 00:01 always ends the quarter.
               if (last_sec) begin
                  state <= S_QEND;
                  sec_q <= '0;
               end else if (gc.shot_cout && !hold) begin
                  state <= S_VIOL;
               end else if (!gc.start_sw) begin
                  state <= S_PAUSE;
               end else if (sec_q == '0) begin
                  sec_q <= SEC_MAX;
                  min_q <= min_q - N'(1);
               end else begin
                  sec_q <= sec_q - N'(1);
               end
            end
            S_PAUSE: begin
               rst_pend <= gc.poss_change;
               if (start_rise) state <= S_RUN;
            end
            S_VIOL: begin
               if (buzz_done) begin
                  state    <= S_PAUSE;
                  buzz_cnt <= '0;
                  rst_pend <= 1'b1;
               end else begin
                  buzz_cnt <= buzz_cnt + BW'(1);
               end
            end
            S_QEND: begin
               if (buzz_done) begin
                  buzz_cnt <= '0;
                  if (qtr_q < QTR_LAST) begin
                     qtr_q    <= qtr_q + N'(1);
                     min_q    <= QMIN;
                     sec_q    <= '0;
                     rst_pend <= 1'b1;
                     state    <= S_PAUSE;
                  end else begin
                     state <= S_OVER;
                  end
               end else begin
                  buzz_cnt <= buzz_cnt + BW'(1);
               end
            end
            S_OVER: begin
               state <= S_OVER;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign gc.shot_en   = (state == S_RUN);
   assign gc.shot_rst  = (state == S_IDLE) | rst_pend;
   assign gc.shot_hold = hold;
   assign gc.buzzer    = (state == S_VIOL) | (state == S_QEND);
   assign gc.game_over = (state == S_OVER);
   assign gc.min_N     = min_q;
   assign gc.sec_N     = sec_q;
   assign gc.quarter_N = qtr_q;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Randomized bench for game_clock_ctrl against a seconds-remaining reference model.
module tb_game_clock_ctrl;

   localparam int unsigned N        = 8;
   localparam int          QMIN     = 2;
   localparam int          QUARTERS = 4;
   localparam int          BUZZ     = 3;
   localparam int          SHOT     = 24;

   logic clk_1Hz = 1'b0;
   logic Reset_Game;

   game_clock_ctrl_if #(.N(N)) gif ();

   game_clock_ctrl #(
      .N           (N),
      .QUARTER_MIN (QMIN),
      .QUARTERS    (QUARTERS),
      .BUZZ_LEN    (BUZZ),
      .SHOT_LEN    (SHOT)
   ) dut (
      .clk_1Hz    (clk_1Hz),
      .Reset_Game (Reset_Game),
      .gc         (gif.slave)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   int errors = 0;
   int checks = 0;

   // Reference model: whole seconds left in the quarter plus a buzzer countdown.
   string m_phase    = "IDLE";
   int    m_rem      = QMIN * 60;
   int    m_qtr      = 1;
   int    m_buzz     = 0;
   int    m_prev_s   = 0;
   int    m_pend     = 0;
   logic  cur_s      = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d expected %0d (phase %s rem %0d qtr %0d)",
                  tag, $time, got, exp, m_phase, m_rem, m_qtr);
      end
   endtask

   task automatic model_step(input logic r, input logic s, input logic p, input logic c);
      int  new_pend;
      bit  rise;
      bit  no_shot;
      if (r) begin
         m_phase  = "IDLE";
         m_rem    = QMIN * 60;
         m_qtr    = 1;
         m_buzz   = 0;
         m_prev_s = 0;
         m_pend   = 0;
         return;
      end
      rise     = s && (m_prev_s == 0);
      no_shot  = (m_rem <= SHOT);
      new_pend = 0;
      if (m_phase == "IDLE") begin
         if (rise) m_phase = "RUN";
      end else if (m_phase == "RUN") begin
         new_pend = int'(p);
         if (m_rem == 1) begin
            m_rem   = 0;
            m_phase = "QEND";
            m_buzz  = BUZZ;
         end else if (c && !no_shot) begin
            m_phase = "VIOL";
            m_buzz  = BUZZ;
         end else if (!s) begin
            m_phase = "PAUSE";
         end else begin
            m_rem = m_rem - 1;
         end
      end else if (m_phase == "PAUSE") begin
         new_pend = int'(p);
         if (rise) m_phase = "RUN";
      end else if (m_phase == "VIOL") begin
         m_buzz--;
         if (m_buzz == 0) begin
            m_phase  = "PAUSE";
            new_pend = 1;
         end
      end else if (m_phase == "QEND") begin
         m_buzz--;
         if (m_buzz == 0) begin
            if (m_qtr < QUARTERS) begin
               m_qtr++;
               m_rem    = QMIN * 60;
               new_pend = 1;
               m_phase  = "PAUSE";
            end else begin
               m_phase = "OVER";
            end
         end
      end
      m_pend   = new_pend;
      m_prev_s = int'(s);
   endtask

   task automatic compare_all();
      check_eq("min",       32'(gif.min_N),     32'(m_rem / 60));
      check_eq("sec",       32'(gif.sec_N),     32'(m_rem % 60));
      check_eq("quarter",   32'(gif.quarter_N), 32'(m_qtr));
      check_eq("shot_en",   32'(gif.shot_en),   32'(m_phase == "RUN"));
      check_eq("shot_rst",  32'(gif.shot_rst),  32'((m_phase == "IDLE") || (m_pend != 0)));
      check_eq("shot_hold", 32'(gif.shot_hold), 32'(m_rem <= SHOT));
      check_eq("buzzer",    32'(gif.buzzer),    32'((m_phase == "VIOL") || (m_phase == "QEND")));
      check_eq("game_over", 32'(gif.game_over), 32'(m_phase == "OVER"));
   endtask

   task automatic tick(input logic r, input logic s, input logic p, input logic c);
      @(negedge clk_1Hz);
      Reset_Game      = r;
      gif.start_sw    = s;
      gif.poss_change = p;
      gif.shot_cout   = c;
      @(posedge clk_1Hz);
      model_step(r, s, p, c);
      #1;
      compare_all();
   endtask

   task automatic rand_tick(input bit allow_reset);
      logic r;
      logic p;
      logic c;
      r = 1'b0;
      if (allow_reset) begin
         if (m_phase == "QEND") r = ($urandom_range(99) < 20);
         else                   r = ($urandom_range(999) < 2);
      end
      if (cur_s) begin
         if ($urandom_range(99) < ((m_phase == "PAUSE" || m_phase == "OVER") ? 30 : 3)) cur_s = 1'b0;
      end else if ($urandom_range(99) < 25) begin
         cur_s = 1'b1;
      end
      p = ($urandom_range(99) < 5);
      if (m_phase == "RUN" && m_rem == 1) c = ($urandom_range(99) < 50);
      else if (m_rem <= SHOT)             c = ($urandom_range(99) < 30);
      else                                c = ($urandom_range(99) < 2);
      tick(r, cur_s, p, c);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      Reset_Game      = 1'b1;
      gif.start_sw    = 1'b0;
      gif.poss_change = 1'b0;
      gif.shot_cout   = 1'b0;

      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("rst_min", 32'(gif.min_N), 32'(QMIN));
      check_eq("rst_sec", 32'(gif.sec_N), 32'd0);
      check_eq("rst_qtr", 32'(gif.quarter_N), 32'd1);

      // Start held high through reset still counts as a rising edge afterwards.
      cur_s = 1'b1;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("start_run", 32'(gif.shot_en), 32'd1);

      // Full game without resets, bounded.
      n = 0;
      while (m_phase != "OVER" && n < 6000) begin
         rand_tick(1'b0);
         n++;
      end
      check_eq("reached_over", 32'(m_phase == "OVER"), 32'd1);

      for (int i = 0; i < 20; i++) rand_tick(1'b0);

      // Random play with resets, biased towards resets during period-end buzzing.
      for (int i = 0; i < 4000; i++) rand_tick(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
